// File: rtl/enc_binder_bank.sv
// enc_binder_bank
// Binds NUM_CH level hypervectors by cyclic rotation, LANES channels per
// clock. Each channel's rotate amount comes from a runtime-programmable
// shift table. One transaction is processed at a time: accept, bind, hold.
//
// Ports
//   i_clk, i_nrst        clock, asynchronous active-high reset
//   i_cfg_we/addr/shift  shift table write port (honoured only while idle)
//   o_cfg_drop           one-cycle pulse when a table write was rejected
//   i_mode               0 rotate left, 1 rotate right, 2/3 bypass
//   i_in_valid/o_in_ready, i_level_hv      input handshake and data
//   o_out_valid/i_out_ready, o_shifted_hv  output handshake and data
//   o_busy               high while binding or holding a result
module enc_binder_bank #(
  parameter int HV_DIM       = 2048,
  parameter int NUM_CH       = 10,
  parameter int LANES        = 2,
  parameter int SHIFT_W      = $clog2(HV_DIM),
  parameter int SHIFT_BASE   = 0,
  parameter int SHIFT_STRIDE = 1,
  parameter int ADDR_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                          i_clk,
  input  logic                          i_nrst,
  input  logic                          i_cfg_we,
  input  logic [ADDR_W-1:0]             i_cfg_addr,
  input  logic [SHIFT_W-1:0]            i_cfg_shift,
  output logic                          o_cfg_drop,
  input  logic [1:0]                    i_mode,
  input  logic                          i_in_valid,
  output logic                          o_in_ready,
  input  logic [NUM_CH-1:0][HV_DIM-1:0] i_level_hv,
  output logic                          o_out_valid,
  input  logic                          i_out_ready,
  output logic [NUM_CH-1:0][HV_DIM-1:0] o_shifted_hv,
  output logic                          o_busy
);

  localparam int NUM_GRP = (NUM_CH + LANES - 1) / LANES;
  localparam int GRP_W   = (NUM_GRP > 1) ? $clog2(NUM_GRP) : 1;

  typedef enum logic [1:0] {IDLE, BIND, HOLD} state_t;

  state_t                          r_state;
  state_t                          w_nextState;
  logic [GRP_W-1:0]                r_grp;
  logic [NUM_CH-1:0][HV_DIM-1:0]   r_inHv;
  logic [1:0]                      r_mode;
  logic [SHIFT_W-1:0]              r_shiftTable [NUM_CH];
  logic [NUM_CH-1:0][HV_DIM-1:0]   r_shiftedHv;
  logic                            r_cfgDrop;
  logic                            w_accept;
  logic                            w_cfgOk;
  logic [HV_DIM-1:0]               w_laneOut [LANES];

  function automatic logic [SHIFT_W-1:0] defaultShift(input int ch);
    int v;
    v = (SHIFT_BASE + ch * SHIFT_STRIDE) % HV_DIM;
    return v[SHIFT_W-1:0];
  endfunction

  // Rotation through a doubled copy: the upper half after a left shift is
  // the left rotation, the lower half after a right shift is the right one.
  function automatic logic [HV_DIM-1:0] rotateHv(input logic [HV_DIM-1:0] v,
                                                 input logic [31:0] s,
                                                 input logic [1:0] m);
    logic [2*HV_DIM-1:0] dbl;
    dbl = {v, v};
    if (m[1]) return v;
    if (m == 2'd0) begin
      dbl = dbl << s;
      return dbl[2*HV_DIM-1:HV_DIM];
    end
    dbl = dbl >> s;
    return dbl[HV_DIM-1:0];
  endfunction

  assign w_accept = (r_state == IDLE) && i_in_valid;
  assign w_cfgOk  = i_cfg_we && (r_state == IDLE) && (32'(i_cfg_addr) < NUM_CH);

  // Shift table: writes are taken only while idle, so a write landing on
  // the accept edge is already visible to the first BIND cycle.
  always_ff @(posedge i_clk or posedge i_nrst) begin
    if (i_nrst) begin
      for (int i = 0; i < NUM_CH; i++) r_shiftTable[i] <= defaultShift(i);
    end else if (w_cfgOk) begin
      r_shiftTable[i_cfg_addr] <= i_cfg_shift;
    end
  end

  // Any rejected write request produces a single-cycle drop pulse.
  always_ff @(posedge i_clk or posedge i_nrst) begin
    if (i_nrst) r_cfgDrop <= 1'b0;
    else        r_cfgDrop <= i_cfg_we && !w_cfgOk;
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_nrst) begin
    if (i_nrst) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  // Next state: one BIND cycle per channel group, then hold until taken.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: if (i_in_valid) w_nextState = BIND;
      BIND: if (r_grp == GRP_W'(NUM_GRP - 1)) w_nextState = HOLD;
      HOLD: if (i_out_ready) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Input capture and group counter.
  always_ff @(posedge i_clk or posedge i_nrst) begin
    if (i_nrst) begin
      r_inHv <= '0;
      r_mode <= 2'd0;
      r_grp  <= '0;
    end else if (w_accept) begin
      r_inHv <= i_level_hv;
      r_mode <= i_mode;
      r_grp  <= '0;
    end else if (r_state == BIND) begin
      r_grp <= r_grp + 1'b1;
    end
  end

  // One rotator per lane; lanes past the last channel read channel 0 and
  // their result is never stored.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [31:0]        w_idx;
    logic [HV_DIM-1:0]  w_src;
    logic [SHIFT_W-1:0] w_shift;
    logic [31:0]        w_eff;
    always_comb begin
      w_idx = 32'(r_grp) * LANES + l;
      if (w_idx >= NUM_CH) w_idx = 32'd0;
      w_src   = r_inHv[ADDR_W'(w_idx)];
      w_shift = r_shiftTable[ADDR_W'(w_idx)];
      w_eff   = 32'(w_shift) % HV_DIM;
    end
    assign w_laneOut[l] = rotateHv(w_src, w_eff, r_mode);
  end

  // Result register: each channel is overwritten only in its own group.
  always_ff @(posedge i_clk or posedge i_nrst) begin
    if (i_nrst) begin
      r_shiftedHv <= '0;
    end else if (r_state == BIND) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (r_grp == GRP_W'(c / LANES)) r_shiftedHv[c] <= w_laneOut[c % LANES];
      end
    end
  end

  assign o_in_ready   = (r_state == IDLE);
  assign o_out_valid  = (r_state == HOLD);
  assign o_busy       = (r_state != IDLE);
  assign o_cfg_drop   = r_cfgDrop;
  assign o_shifted_hv = r_shiftedHv;

endmodule

// File: tb/tb_enc_binder_bank.sv
module tb_enc_binder_bank;

  localparam int HV  = 16;
  localparam int NCH = 10;
  localparam int LN  = 4;
  localparam int AW  = 4;
  localparam int SW  = 4;
  localparam int TMO = 50;

  typedef logic [NCH-1:0][HV-1:0] bank_t;

  logic           clk;
  logic           nrst;
  logic           cfgWe;
  logic [AW-1:0]  cfgAddr;
  logic [SW-1:0]  cfgShift;
  logic           cfgDrop;
  logic [1:0]     mode;
  logic           inValid;
  logic           inReady;
  bank_t          levelHv;
  logic           outValid;
  logic           outReady;
  bank_t          shiftedHv;
  logic           busy;

  int    totalCnt;
  int    badCnt;
  int    tbShift [NCH];
  bank_t sbQ [$];

  enc_binder_bank #(
    .HV_DIM(HV), .NUM_CH(NCH), .LANES(LN), .SHIFT_W(SW),
    .SHIFT_BASE(0), .SHIFT_STRIDE(1), .ADDR_W(AW)
  ) dut (
    .i_clk(clk), .i_nrst(nrst),
    .i_cfg_we(cfgWe), .i_cfg_addr(cfgAddr), .i_cfg_shift(cfgShift),
    .o_cfg_drop(cfgDrop), .i_mode(mode),
    .i_in_valid(inValid), .o_in_ready(inReady), .i_level_hv(levelHv),
    .o_out_valid(outValid), .i_out_ready(outReady),
    .o_shifted_hv(shiftedHv), .o_busy(busy)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference rotation written straight from the bit-mapping definition.
  function automatic logic [HV-1:0] modelRot(input logic [HV-1:0] v, input int s,
                                             input logic [1:0] m);
    logic [HV-1:0] r;
    r = '0;
    s = s % HV;
    if (m >= 2'd2) return v;
    for (int j = 0; j < HV; j++) begin
      if (m == 2'd0) r[(j + s) % HV] = v[j];
      else           r[j] = v[(j + s) % HV];
    end
    return r;
  endfunction

  function automatic bank_t modelBank(input bank_t v, input logic [1:0] m);
    bank_t r;
    for (int c = 0; c < NCH; c++) r[c] = modelRot(v[c], tbShift[c], m);
    return r;
  endfunction

  function automatic void resetModel();
    for (int c = 0; c < NCH; c++) tbShift[c] = c;
  endfunction

  // Drive one input at a falling edge, push its expected result, and return
  // at the falling edge after the accept with in_valid removed.
  task automatic applyStimulus(input bank_t hv, input logic [1:0] m);
    inValid = 1'b1;
    levelHv = hv;
    mode    = m;
    sbQ.push_back(modelBank(hv, m));
    @(posedge clk);
    @(negedge clk);
    inValid = 1'b0;
  endtask

  // Bounded wait for out_valid, sampled on falling edges.
  task automatic waitOutValid(output int cycles);
    cycles = 0;
    while (!outValid && cycles < TMO) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset();
    nrst = 1'b1;
    #1;
    totalCnt++;
    if (shiftedHv !== '0 || outValid !== 1'b0 || busy !== 1'b0 || cfgDrop !== 1'b0) begin
      badCnt++;
      $display("[TB] FAIL reset_outputs: got hv=%h ov=%b busy=%b drop=%b required all zero",
               shiftedHv, outValid, busy, cfgDrop);
    end
    repeat (2) @(negedge clk);
    nrst = 1'b0;
    @(negedge clk);
    totalCnt++;
    if (inReady !== 1'b1) begin
      badCnt++;
      $display("[TB] FAIL reset_in_ready: got %b required 1", inReady);
    end
  endtask

  task automatic test_rotate_left();
    bank_t hv;
    bank_t exp;
    int    cyc;
    for (int c = 0; c < NCH; c++) hv[c] = 16'h0001;
    outReady = 1'b1;
    applyStimulus(hv, 2'd0);
    waitOutValid(cyc);
    totalCnt++;
    if (cyc != 3) begin
      badCnt++;
      $display("[TB] FAIL left_latency: got %0d cycles required 3", cyc);
    end
    exp = sbQ.pop_front();
    totalCnt++;
    if (shiftedHv !== exp) begin
      badCnt++;
      $display("[TB] FAIL left_result: got %h required %h", shiftedHv, exp);
    end
    totalCnt++;
    if (shiftedHv[0] !== 16'h0001 || shiftedHv[9] !== 16'h0200) begin
      badCnt++;
      $display("[TB] FAIL left_ch0_ch9: got %h/%h required 0001/0200", shiftedHv[0], shiftedHv[9]);
    end
    @(negedge clk);
    totalCnt++;
    if (outValid !== 1'b0 || inReady !== 1'b1) begin
      badCnt++;
      $display("[TB] FAIL left_pulse: got ov=%b ir=%b required ov=0 ir=1", outValid, inReady);
    end
  endtask

  task automatic test_right_bypass();
    bank_t hv;
    bank_t exp;
    int    cyc;
    hv = '0;
    hv[3] = 16'h0001;
    applyStimulus(hv, 2'd1);
    waitOutValid(cyc);
    exp = sbQ.pop_front();
    totalCnt++;
    if (cyc >= TMO || shiftedHv !== exp) begin
      badCnt++;
      $display("[TB] FAIL right_result: got %h required %h", shiftedHv, exp);
    end
    totalCnt++;
    if (shiftedHv[3] !== 16'h2000) begin
      badCnt++;
      $display("[TB] FAIL right_ch3: got %h required 2000", shiftedHv[3]);
    end
    @(negedge clk);
    for (int c = 0; c < NCH; c++) hv[c] = 16'h0001;
    applyStimulus(hv, 2'd2);
    waitOutValid(cyc);
    exp = sbQ.pop_front();
    totalCnt++;
    if (cyc >= TMO || shiftedHv !== exp) begin
      badCnt++;
      $display("[TB] FAIL bypass_result: got %h required %h", shiftedHv, exp);
    end
    for (int c = 0; c < NCH; c++) begin
      totalCnt++;
      if (shiftedHv[c] !== 16'h0001) begin
        badCnt++;
        $display("[TB] FAIL bypass_ch%0d: got %h required 0001", c, shiftedHv[c]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_cfg_write();
    bank_t hv;
    bank_t exp;
    int    cyc;
    for (int c = 0; c < NCH; c++) hv[c] = 16'h0001;
    hv[5] = 16'h8001;
    cfgWe    = 1'b1;
    cfgAddr  = 4'd5;
    cfgShift = 4'd4;
    tbShift[5] = 4;
    applyStimulus(hv, 2'd0);
    cfgWe = 1'b0;
    totalCnt++;
    if (cfgDrop !== 1'b0) begin
      badCnt++;
      $display("[TB] FAIL cfg_ok_nodrop: got %b required 0", cfgDrop);
    end
    waitOutValid(cyc);
    exp = sbQ.pop_front();
    totalCnt++;
    if (cyc >= TMO || shiftedHv !== exp) begin
      badCnt++;
      $display("[TB] FAIL cfg_write_result: got %h required %h", shiftedHv, exp);
    end
    totalCnt++;
    if (shiftedHv[5] !== 16'h0018) begin
      badCnt++;
      $display("[TB] FAIL cfg_write_ch5: got %h required 0018", shiftedHv[5]);
    end
    @(negedge clk);
    cfgWe    = 1'b1;
    cfgAddr  = 4'd12;
    cfgShift = 4'd9;
    @(negedge clk);
    cfgWe = 1'b0;
    totalCnt++;
    if (cfgDrop !== 1'b1) begin
      badCnt++;
      $display("[TB] FAIL cfg_range_drop: got %b required 1", cfgDrop);
    end
    @(negedge clk);
    totalCnt++;
    if (cfgDrop !== 1'b0) begin
      badCnt++;
      $display("[TB] FAIL cfg_range_pulse: got %b required 0", cfgDrop);
    end
    for (int c = 0; c < NCH; c++) hv[c] = 16'h0001;
    applyStimulus(hv, 2'd0);
    waitOutValid(cyc);
    exp = sbQ.pop_front();
    totalCnt++;
    if (cyc >= TMO || shiftedHv !== exp) begin
      badCnt++;
      $display("[TB] FAIL cfg_range_table: got %h required %h", shiftedHv, exp);
    end
    @(negedge clk);
  endtask

  task automatic test_hold();
    bank_t hv;
    bank_t exp;
    int    cyc;
    for (int c = 0; c < NCH; c++) hv[c] = 16'(16'h1357 * (c + 1));
    outReady = 1'b0;
    applyStimulus(hv, 2'd1);
    waitOutValid(cyc);
    exp = sbQ.pop_front();
    for (int k = 0; k < 6; k++) begin
      totalCnt++;
      if (cyc >= TMO || outValid !== 1'b1 || shiftedHv !== exp || inReady !== 1'b0 || busy !== 1'b1) begin
        badCnt++;
        $display("[TB] FAIL hold_cycle%0d: got ov=%b ir=%b busy=%b hv=%h required ov=1 ir=0 busy=1 hv=%h",
                 k, outValid, inReady, busy, shiftedHv, exp);
      end
      @(negedge clk);
    end
    outReady = 1'b1;
    @(negedge clk);
    totalCnt++;
    if (outValid !== 1'b0 || inReady !== 1'b1 || busy !== 1'b0) begin
      badCnt++;
      $display("[TB] FAIL hold_release: got ov=%b ir=%b busy=%b required 0 1 0", outValid, inReady, busy);
    end
  endtask

  task automatic test_cfg_during_bind();
    bank_t hv;
    bank_t exp;
    int    cyc;
    for (int c = 0; c < NCH; c++) hv[c] = 16'h00F1;
    applyStimulus(hv, 2'd0);
    cfgWe    = 1'b1;
    cfgAddr  = 4'd2;
    cfgShift = 4'd7;
    @(negedge clk);
    cfgWe = 1'b0;
    totalCnt++;
    if (cfgDrop !== 1'b1) begin
      badCnt++;
      $display("[TB] FAIL bind_cfg_drop: got %b required 1", cfgDrop);
    end
    @(negedge clk);
    totalCnt++;
    if (cfgDrop !== 1'b0) begin
      badCnt++;
      $display("[TB] FAIL bind_cfg_pulse: got %b required 0", cfgDrop);
    end
    waitOutValid(cyc);
    exp = sbQ.pop_front();
    totalCnt++;
    if (cyc >= TMO || shiftedHv !== exp) begin
      badCnt++;
      $display("[TB] FAIL bind_cfg_old_shift: got %h required %h", shiftedHv, exp);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_bind();
    bank_t hv;
    bank_t exp;
    int    cyc;
    for (int c = 0; c < NCH; c++) hv[c] = 16'hA5C3;
    applyStimulus(hv, 2'd0);
    @(negedge clk);
    nrst = 1'b1;
    #1;
    totalCnt++;
    if (shiftedHv !== '0 || outValid !== 1'b0 || busy !== 1'b0 || cfgDrop !== 1'b0) begin
      badCnt++;
      $display("[TB] FAIL midbind_reset: got hv=%h ov=%b busy=%b drop=%b required all zero",
               shiftedHv, outValid, busy, cfgDrop);
    end
    sbQ.delete();
    resetModel();
    @(negedge clk);
    nrst = 1'b0;
    @(negedge clk);
    totalCnt++;
    if (inReady !== 1'b1) begin
      badCnt++;
      $display("[TB] FAIL midbind_in_ready: got %b required 1", inReady);
    end
    for (int c = 0; c < NCH; c++) hv[c] = 16'h0001;
    applyStimulus(hv, 2'd0);
    waitOutValid(cyc);
    exp = sbQ.pop_front();
    totalCnt++;
    if (cyc >= TMO || shiftedHv !== exp) begin
      badCnt++;
      $display("[TB] FAIL midbind_defaults: got %h required %h", shiftedHv, exp);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    bank_t      hv;
    bank_t      exp;
    int         cyc;
    int         addr;
    int         sh;
    logic [1:0] m;
    for (int k = 0; k < 5; k++) begin
      addr = $urandom_range(0, NCH - 1);
      sh   = $urandom_range(0, 15);
      cfgWe    = 1'b1;
      cfgAddr  = AW'(addr);
      cfgShift = SW'(sh);
      tbShift[addr] = sh;
      for (int c = 0; c < NCH; c++) hv[c] = 16'($urandom);
      m = 2'($urandom_range(0, 3));
      outReady = 1'b0;
      applyStimulus(hv, m);
      cfgWe = 1'b0;
      waitOutValid(cyc);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      exp = sbQ.pop_front();
      totalCnt++;
      if (cyc >= TMO || shiftedHv !== exp) begin
        badCnt++;
        $display("[TB] FAIL b2b_txn%0d: got %h required %h", k, shiftedHv, exp);
      end
      outReady = 1'b1;
      @(negedge clk);
    end
  endtask

  // Test sequence.
  initial begin
    totalCnt = 0;
    badCnt   = 0;
    cfgWe    = 1'b0;
    cfgAddr  = '0;
    cfgShift = '0;
    mode     = 2'd0;
    inValid  = 1'b0;
    levelHv  = '0;
    outReady = 1'b1;
    resetModel();
    @(negedge clk);
    test_reset();
    test_rotate_left();
    test_right_bypass();
    test_cfg_write();
    test_hold();
    test_cfg_during_bind();
    test_reset_mid_bind();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
    $finish;
  end

endmodule
